cory_axis_wr_master: RTL and testbench
======================================

// Module: cory_axis_wr_master
// PURPOSE
//  Burst write master feeding the AXI-style memory slave (aw/w/b channels).
//  Takes one command (byte base address, word count) plus a valid/ready data stream.
//  Splits the transfer into bursts of at most 2^L beats that never cross a 4 KB boundary.
//  Keeps exactly one burst outstanding and pulses o_done after the final write response.
// PARAMETERS
//  A  32  address width (byte address)
//  D  64  data width; NUM_BYTE = D/8 bytes per beat
//  L  4   burst length field width; max beats per burst MAX_BEATS = 2^L
// PORTS
//  clk        in   1  clock
//  reset_n    in   1  async active-low reset
//  i_cmd_v    in   1  command valid
//  i_cmd_a    in   A  start byte address, NUM_BYTE aligned
//  i_cmd_n    in   A  number of D-bit words to write (0 allowed)
//  o_cmd_r    out  1  command ready
//  i_d_v      in   1  source data valid
//  i_d_d      in   D  source data
//  o_d_r      out  1  source data ready
//  o_aw_v     out  1  write address valid
//  o_aw_a     out  A  burst start byte address
//  o_aw_l     out  L  burst length, beats-1
//  i_aw_r     in   1  write address ready
//  o_w_v      out  1  write data valid
//  o_w_d      out  D  write data
//  o_w_l      out  1  last beat of burst
//  i_w_r      in   1  write data ready
//  i_b_v      in   1  write response valid
//  o_b_r      out  1  write response ready
//  o_busy     out  1  command in progress (state != IDLE)
//  o_done     out  1  one-cycle pulse, command complete
// BEHAVIOUR
//  Reset: state=IDLE; o_aw_v, o_w_v, o_w_l, o_b_r, o_busy and o_done are 0.
//   Address, remaining-count and beat registers clear to 0.
//   Reset mid-burst aborts the burst immediately; no further beats are driven.
//  FSM IDLE->AW->W->B->(AW|IDLE). o_cmd_r = (state==IDLE).
//  IDLE: on i_cmd_v&o_cmd_r, latch addr=i_cmd_a, rem=i_cmd_n.
//   rem==0: go to DONE0; o_done pulses the next cycle; no bus activity; return to IDLE.
//   rem!=0: go to AW.
//  Burst length, computed on entry to AW and held in a registered L+1-bit field:
//   beats = min(rem, MAX_BEATS, (4096-(addr&12'hFFF))/NUM_BYTE).
//  AW: o_aw_v=1; o_aw_a=addr, o_aw_l=beats-1.
//   Both stay stable until i_aw_r; advance to W on the handshake cycle.
//  W: o_w_v=i_d_v, o_w_d=i_d_d, o_d_r=i_w_r. Direct pass-through, zero latency.
//   o_w_v is never a function of i_w_r.
//   A beat transfers when i_d_v&i_w_r. The L-bit beat counter starts at beats-1,
//   decrements per beat, and o_w_l=(cnt==0).
//   Last beat transferred -> B. Outside W, o_w_v=0 and o_d_r=0.
//  B: o_b_r=1. On i_b_v: addr+=beats*NUM_BYTE (A-bit wrap), rem-=beats.
//   rem==0: IDLE, with o_done=1 for that one cycle. Otherwise go to AW.
//  A new command cannot be accepted in the same cycle as o_done.
//   o_cmd_r rises the cycle after o_done.
//  i_b_v outside B and i_aw_r outside AW are ignored.
//  Sim-only checks ($display ERROR):
//   i_cmd_a not NUM_BYTE aligned;
//   unknown (X) i_d_d on a transferred beat;
//   i_cmd_v while busy held >1e6 cycles (hang).
// STRUCTURE
//  Shared package:
//   - NUM_BYTE, BYTE_ADDR=f_log2(NUM_BYTE), MAX_BEATS, 4 KB page constant;
//   - state encodings IDLE/AW/W/B/DONE0.
//  Sub-module cory_axis_burst_calc (combinational): in addr, rem; out beats (L+1 bits).
//   Reused by the future read master.
//  Top: FSM, addr/rem/beat registers, pass-through muxes.
// TESTING (D=64, L=4, downstream = cory memory model, read back and compare)
//  1 cmd a=0x000 n=16 -> one AW a=0x000 l=15; 16 W beats, o_w_l on 16th;
//    after b, o_done 1 cycle.
//  2 cmd a=0x100 n=40 -> AW 0x100 l=15, AW 0x180 l=15, AW 0x200 l=7;
//    each AW only after previous b; mem words 0x20..0x47 match source.
//  3 cmd a=0xFC0 n=16 -> AW 0xFC0 l=7, then AW 0x1000 l=7 (4 KB split).
//  4 cmd n=0 -> no AW/W; o_done exactly 1 cycle after accept; o_cmd_r high next cycle.
//  5 backpressure: i_aw_r low 5 cycles, i_w_r toggling, i_d_v gaps on n=20
//    -> o_aw_a/o_aw_l stable while stalled; 20 beats in order; no dup/loss.
//  6 reset_n low during beat 7 of 16 -> all outputs 0 asynchronously;
//    after release, cmd a=0x0 n=4 completes normally.

Source files
------------

// File: rtl/cory_axis_wr_master_pkg.sv
// Shared constants, helpers and state encodings
// for the cory AXI-style burst write master.
package cory_axis_wr_master_pkg;

  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_BITS  = 12;

  function automatic int f_log2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int DEF_D     = 64;
  localparam int DEF_L     = 4;
  localparam int NUM_BYTE  = DEF_D / 8;
  localparam int BYTE_ADDR = f_log2(NUM_BYTE);
  localparam int MAX_BEATS = 1 << DEF_L;

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE0
  } state_e;

endpackage

// File: rtl/cory_axis_burst_calc.sv
// Beats for the next burst: bounded by remaining
// words, max burst length and the 4 KB page edge.
import cory_axis_wr_master_pkg::*;

module cory_axis_burst_calc #(
  parameter int A = 32,
  parameter int D = 64,
  parameter int L = 4
) (
  input  logic [A-1:0] addr_i,
  input  logic [A-1:0] rem_i,
  output logic [L:0]   beats_o
);

  localparam int NB = D / 8;
  localparam int BA = f_log2(NB);
  localparam logic [12:0] MAXB = 13'(1 << L);

  logic [12:0] page_left;
  logic [12:0] cap;
  logic        unused_hi;

  assign unused_hi = ^addr_i[A-1:PAGE_BITS];

  assign page_left =
    (13'(PAGE_BYTES) -
     {1'b0, addr_i[PAGE_BITS-1:0]}) >> BA;

  assign cap = (page_left < MAXB) ?
               page_left : MAXB;

  assign beats_o = (rem_i < A'(cap)) ?
                   (L+1)'(rem_i) : (L+1)'(cap);

endmodule

// File: rtl/cory_axis_wr_master.sv
// Burst write master: splits one command into
// 4 KB-safe bursts, one outstanding at a time.
import cory_axis_wr_master_pkg::*;

module cory_axis_wr_master #(
  parameter int A = 32,
  parameter int D = 64,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_cmd_v,
  input  logic [A-1:0] i_cmd_a,
  input  logic [A-1:0] i_cmd_n,
  output logic         o_cmd_r,
  input  logic         i_d_v,
  input  logic [D-1:0] i_d_d,
  output logic         o_d_r,
  output logic         o_aw_v,
  output logic [A-1:0] o_aw_a,
  output logic [L-1:0] o_aw_l,
  input  logic         i_aw_r,
  output logic         o_w_v,
  output logic [D-1:0] o_w_d,
  output logic         o_w_l,
  input  logic         i_w_r,
  input  logic         i_b_v,
  output logic         o_b_r,
  output logic         o_busy,
  output logic         o_done
);

  localparam int NB = D / 8;
  localparam int BA = f_log2(NB);

  state_e       state_q;
  logic [A-1:0] addr_q;
  logic [A-1:0] rem_q;
  logic [L:0]   beats_q;
  logic [L-1:0] cnt_q;
  logic         aw_v_q;
  logic         b_r_q;
  logic         done_q;

  logic [A-1:0] nxt_addr;
  logic [A-1:0] nxt_rem;
  logic [A-1:0] calc_addr;
  logic [A-1:0] calc_rem;
  logic [L:0]   calc_beats;
  logic         in_w;
  logic         beat;

  assign nxt_addr  = addr_q + (A'(beats_q) << BA);
  assign nxt_rem   = rem_q - A'(beats_q);
  assign calc_addr = (state_q == IDLE) ?
                     i_cmd_a : nxt_addr;
  assign calc_rem  = (state_q == IDLE) ?
                     i_cmd_n : nxt_rem;

  cory_axis_burst_calc #(
    .A(A),
    .D(D),
    .L(L)
  ) u_calc (
    .addr_i (calc_addr),
    .rem_i  (calc_rem),
    .beats_o(calc_beats)
  );

  assign in_w = (state_q == W);
  assign beat = in_w & i_d_v & i_w_r;

  // Command sequencing: AW -> W -> B per burst.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      aw_v_q  <= 1'b0;
      b_r_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (i_cmd_v) begin
          addr_q  <= i_cmd_a;
          rem_q   <= i_cmd_n;
          beats_q <= calc_beats;
          if (i_cmd_n == '0) begin
            state_q <= DONE0;
            done_q  <= 1'b1;
          end else begin
            state_q <= AW;
            aw_v_q  <= 1'b1;
          end
        end
        AW: if (i_aw_r) begin
          aw_v_q  <= 1'b0;
          cnt_q   <= beats_q[L-1:0] - L'(1);
          state_q <= W;
        end
        W: if (beat) begin
          if (cnt_q == '0) begin
            state_q <= B;
            b_r_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - L'(1);
          end
        end
        B: if (i_b_v) begin
          b_r_q   <= 1'b0;
          addr_q  <= nxt_addr;
          rem_q   <= nxt_rem;
          beats_q <= calc_beats;
          if (nxt_rem == '0) begin
            state_q <= DONE0;
            done_q  <= 1'b1;
          end else begin
            state_q <= AW;
            aw_v_q  <= 1'b1;
          end
        end
        DONE0: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_r = (state_q == IDLE);
  assign o_busy  = (state_q != IDLE);
  assign o_aw_v  = aw_v_q;
  assign o_aw_a  = aw_v_q ? addr_q : '0;
  assign o_aw_l  = aw_v_q ?
                   (beats_q[L-1:0] - L'(1)) : '0;
  assign o_w_v   = in_w & i_d_v;
  assign o_w_d   = in_w ? i_d_d : '0;
  assign o_w_l   = in_w & (cnt_q == '0);
  assign o_d_r   = in_w & i_w_r;
  assign o_b_r   = b_r_q;
  assign o_done  = done_q;

`ifndef SYNTHESIS
  int unsigned hang_q;

  // Flag misaligned commands, X data, stuck requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hang_q <= 0;
    end else begin
      if (i_cmd_v && o_cmd_r &&
          ((i_cmd_a & A'(NB - 1)) != '0))
        $display("ERROR cmd addr %0h unaligned",
                 i_cmd_a);
      if (beat && $isunknown(i_d_d))
        $display("ERROR unknown write data");
      if (i_cmd_v && o_busy)
        hang_q <= hang_q + 1;
      else
        hang_q <= 0;
      if (hang_q == 32'd1000000)
        $display("ERROR cmd_v held while busy");
    end
  end
`endif

endmodule

// File: tb/tb_cory_axis_wr_master.sv
// Directed bench: memory-model slave, source model,
// per-scenario tasks with hand-computed expectations.
module tb_cory_axis_wr_master;

  localparam int A = 32;
  localparam int D = 64;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_cmd_v = 1'b0;
  logic [A-1:0] i_cmd_a = '0;
  logic [A-1:0] i_cmd_n = '0;
  logic         o_cmd_r;
  logic         i_d_v;
  logic [D-1:0] i_d_d;
  logic         o_d_r;
  logic         o_aw_v;
  logic [A-1:0] o_aw_a;
  logic [L-1:0] o_aw_l;
  logic         i_aw_r;
  logic         o_w_v;
  logic [D-1:0] o_w_d;
  logic         o_w_l;
  logic         i_w_r;
  logic         i_b_v;
  logic         o_b_r;
  logic         o_busy;
  logic         o_done;

  always #5 clk = ~clk;

  cory_axis_wr_master #(.A(A), .D(D), .L(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_cmd_v(i_cmd_v), .i_cmd_a(i_cmd_a),
    .i_cmd_n(i_cmd_n), .o_cmd_r(o_cmd_r),
    .i_d_v(i_d_v), .i_d_d(i_d_d), .o_d_r(o_d_r),
    .o_aw_v(o_aw_v), .o_aw_a(o_aw_a),
    .o_aw_l(o_aw_l), .i_aw_r(i_aw_r),
    .o_w_v(o_w_v), .o_w_d(o_w_d), .o_w_l(o_w_l),
    .i_w_r(i_w_r), .i_b_v(i_b_v), .o_b_r(o_b_r),
    .o_busy(o_busy), .o_done(o_done)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int aw_delay = 0;
  bit w_toggle = 1'b0;
  bit d_gaps   = 1'b0;

  int cyc     = 0;
  int src_idx = 0;
  logic [63:0] mem [0:1023];

  int n_aw        = 0;
  int beats_tot   = 0;
  int last_err    = 0;
  int order_err   = 0;
  int aw_unstable = 0;
  int done_cnt    = 0;
  logic [A-1:0] aw_a_log [0:63];
  logic [L-1:0] aw_l_log [0:63];

  int           aw_wait    = 0;
  bit           b_pend     = 1'b0;
  bit           burst_open = 1'b0;
  bit           hold_v     = 1'b0;
  logic [A-1:0] hold_a     = '0;
  logic [L-1:0] hold_l     = '0;
  int           cur_word   = 0;
  int           bib        = 0;
  logic [L-1:0] cur_len    = '0;

  function automatic logic [63:0] src_data(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  assign i_d_d  = src_data(src_idx);
  assign i_d_v  = !(d_gaps && (cyc % 3 == 0));
  assign i_aw_r = o_aw_v && (aw_wait >= aw_delay);
  assign i_w_r  = w_toggle ? cyc[0] : 1'b1;
  assign i_b_v  = b_pend;

  // memory-model slave plus bus monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_done) done_cnt <= done_cnt + 1;
    if (i_d_v && o_d_r) src_idx <= src_idx + 1;
    if (!reset_n) begin
      aw_wait    <= 0;
      b_pend     <= 1'b0;
      burst_open <= 1'b0;
      hold_v     <= 1'b0;
      bib        <= 0;
    end else begin
      if (o_aw_v) begin
        if (hold_v && (o_aw_a !== hold_a ||
                       o_aw_l !== hold_l))
          aw_unstable <= aw_unstable + 1;
        hold_a <= o_aw_a;
        hold_l <= o_aw_l;
        hold_v <= !i_aw_r;
        if (i_aw_r) begin
          if (burst_open || b_pend)
            order_err <= order_err + 1;
          aw_a_log[n_aw[5:0]] <= o_aw_a;
          aw_l_log[n_aw[5:0]] <= o_aw_l;
          n_aw       <= n_aw + 1;
          aw_wait    <= 0;
          burst_open <= 1'b1;
          cur_word   <= int'(o_aw_a >> 3);
          cur_len    <= o_aw_l;
          bib        <= 0;
        end else begin
          aw_wait <= aw_wait + 1;
        end
      end
      if (o_w_v && i_w_r) begin
        if (!burst_open || b_pend)
          order_err <= order_err + 1;
        if (o_w_l !== (bib == int'(cur_len)))
          last_err <= last_err + 1;
        if (cur_word >= 0 && cur_word < 1024)
          mem[cur_word] <= o_w_d;
        cur_word  <= cur_word + 1;
        bib       <= bib + 1;
        beats_tot <= beats_tot + 1;
        if (o_w_l) b_pend <= 1'b1;
      end
      if (b_pend && o_b_r) begin
        b_pend     <= 1'b0;
        burst_open <= 1'b0;
      end
    end
  end

  task automatic do_cmd(input logic [A-1:0] a,
                        input logic [A-1:0] n,
                        input int lim,
                        output bit ok);
    int k;
    @(negedge clk);
    i_cmd_v = 1'b1;
    i_cmd_a = a;
    i_cmd_n = n;
    k = 0;
    while (!o_cmd_r && k < lim) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    i_cmd_v = 1'b0;
    ok = 1'b0;
    k = 0;
    while (k < lim) begin
      if (o_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({o_aw_v, o_w_v, o_w_l, o_b_r,
         o_busy, o_done} !== 6'b0)
      $display("FAIL rst_outs got=%b exp=000000",
               {o_aw_v, o_w_v, o_w_l, o_b_r,
                o_busy, o_done});
    else pass_cnt++;
    chk_cnt++;
    if (o_cmd_r !== 1'b1)
      $display("FAIL rst_cmd_r got=%b exp=1", o_cmd_r);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int aw0 = n_aw;
    int bt0 = beats_tot;
    int le0 = last_err;
    int dc0 = done_cnt;
    int s0  = src_idx;
    int bad = 0;
    do_cmd(32'h0, 32'd16, 400, ok);
    chk_cnt++;
    if (!ok) $display("FAIL t1_done got=timeout exp=done");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (o_done !== 1'b0 || o_cmd_r !== 1'b1)
      $display("FAIL t1_pulse got=%b%b exp=01",
               o_done, o_cmd_r);
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt - dc0 != 1)
      $display("FAIL t1_done_cnt got=%0d exp=1",
               done_cnt - dc0);
    else pass_cnt++;
    chk_cnt++;
    if (n_aw - aw0 != 1)
      $display("FAIL t1_n_aw got=%0d exp=1", n_aw - aw0);
    else pass_cnt++;
    chk_cnt++;
    if (aw_a_log[aw0] !== 32'h0 || aw_l_log[aw0] !== 4'd15)
      $display("FAIL t1_aw got=%0h/%0d exp=0/15",
               aw_a_log[aw0], aw_l_log[aw0]);
    else pass_cnt++;
    chk_cnt++;
    if (beats_tot - bt0 != 16 || last_err != le0)
      $display("FAIL t1_beats got=%0d/%0d exp=16/0",
               beats_tot - bt0, last_err - le0);
    else pass_cnt++;
    for (int k = 0; k < 16; k++)
      if (mem[k] !== src_data(s0 + k)) bad++;
    chk_cnt++;
    if (bad != 0)
      $display("FAIL t1_mem got=%0d bad exp=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_multi();
    bit ok;
    int aw0 = n_aw;
    int oe0 = order_err;
    int le0 = last_err;
    int s0  = src_idx;
    int bad = 0;
    logic [A-1:0] ea [3] = '{32'h100, 32'h180, 32'h200};
    logic [L-1:0] el [3] = '{4'd15, 4'd15, 4'd7};
    do_cmd(32'h100, 32'd40, 600, ok);
    chk_cnt++;
    if (!ok) $display("FAIL t2_done got=timeout exp=done");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (n_aw - aw0 != 3)
      $display("FAIL t2_n_aw got=%0d exp=3", n_aw - aw0);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if (aw_a_log[aw0+k] !== ea[k] ||
          aw_l_log[aw0+k] !== el[k])
        $display("FAIL t2_aw%0d got=%0h/%0d exp=%0h/%0d",
                 k, aw_a_log[aw0+k], aw_l_log[aw0+k],
                 ea[k], el[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (order_err != oe0 || last_err != le0)
      $display("FAIL t2_order got=%0d/%0d exp=0/0",
               order_err - oe0, last_err - le0);
    else pass_cnt++;
    for (int k = 0; k < 40; k++)
      if (mem[32'h20 + k] !== src_data(s0 + k)) bad++;
    chk_cnt++;
    if (bad != 0)
      $display("FAIL t2_mem got=%0d bad exp=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_page_split();
    bit ok;
    int aw0 = n_aw;
    int s0  = src_idx;
    int bad = 0;
    do_cmd(32'hFC0, 32'd16, 400, ok);
    chk_cnt++;
    if (!ok) $display("FAIL t3_done got=timeout exp=done");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (n_aw - aw0 != 2)
      $display("FAIL t3_n_aw got=%0d exp=2", n_aw - aw0);
    else pass_cnt++;
    chk_cnt++;
    if (aw_a_log[aw0] !== 32'hFC0 || aw_l_log[aw0] !== 4'd7)
      $display("FAIL t3_aw0 got=%0h/%0d exp=fc0/7",
               aw_a_log[aw0], aw_l_log[aw0]);
    else pass_cnt++;
    chk_cnt++;
    if (aw_a_log[aw0+1] !== 32'h1000 ||
        aw_l_log[aw0+1] !== 4'd7)
      $display("FAIL t3_aw1 got=%0h/%0d exp=1000/7",
               aw_a_log[aw0+1], aw_l_log[aw0+1]);
    else pass_cnt++;
    for (int k = 0; k < 16; k++)
      if (mem[32'h1F8 + k] !== src_data(s0 + k)) bad++;
    chk_cnt++;
    if (bad != 0)
      $display("FAIL t3_mem got=%0d bad exp=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_zero_len();
    int aw0 = n_aw;
    int bt0 = beats_tot;
    @(negedge clk);
    i_cmd_v = 1'b1;
    i_cmd_a = 32'h800;
    i_cmd_n = 32'd0;
    chk_cnt++;
    if (o_cmd_r !== 1'b1)
      $display("FAIL t4_ready got=%b exp=1", o_cmd_r);
    else pass_cnt++;
    @(negedge clk);
    i_cmd_v = 1'b0;
    chk_cnt++;
    if ({o_done, o_cmd_r, o_busy} !== 3'b101)
      $display("FAIL t4_done got=%b exp=101",
               {o_done, o_cmd_r, o_busy});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({o_done, o_cmd_r, o_busy} !== 3'b010)
      $display("FAIL t4_after got=%b exp=010",
               {o_done, o_cmd_r, o_busy});
    else pass_cnt++;
    chk_cnt++;
    if (n_aw != aw0 || beats_tot != bt0)
      $display("FAIL t4_bus got=%0d/%0d exp=0/0",
               n_aw - aw0, beats_tot - bt0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    bit ok;
    int aw0 = n_aw;
    int au0 = aw_unstable;
    int bt0 = beats_tot;
    int le0 = last_err;
    int oe0 = order_err;
    int s0  = src_idx;
    int bad = 0;
    aw_delay = 5;
    w_toggle = 1'b1;
    d_gaps   = 1'b1;
    do_cmd(32'h300, 32'd20, 1000, ok);
    aw_delay = 0;
    w_toggle = 1'b0;
    d_gaps   = 1'b0;
    chk_cnt++;
    if (!ok) $display("FAIL t5_done got=timeout exp=done");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (n_aw - aw0 != 2 ||
        aw_a_log[aw0] !== 32'h300 ||
        aw_l_log[aw0] !== 4'd15 ||
        aw_a_log[aw0+1] !== 32'h380 ||
        aw_l_log[aw0+1] !== 4'd3)
      $display("FAIL t5_aw got=%0d %0h/%0d %0h/%0d exp=2 300/15 380/3",
               n_aw - aw0, aw_a_log[aw0], aw_l_log[aw0],
               aw_a_log[aw0+1], aw_l_log[aw0+1]);
    else pass_cnt++;
    chk_cnt++;
    if (aw_unstable != au0)
      $display("FAIL t5_aw_stable got=%0d exp=0",
               aw_unstable - au0);
    else pass_cnt++;
    chk_cnt++;
    if (beats_tot - bt0 != 20 || last_err != le0 ||
        order_err != oe0)
      $display("FAIL t5_beats got=%0d/%0d/%0d exp=20/0/0",
               beats_tot - bt0, last_err - le0,
               order_err - oe0);
    else pass_cnt++;
    for (int k = 0; k < 20; k++)
      if (mem[32'h60 + k] !== src_data(s0 + k)) bad++;
    chk_cnt++;
    if (bad != 0)
      $display("FAIL t5_mem got=%0d bad exp=0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    int bt0 = beats_tot;
    int btr;
    int aw0;
    int s0;
    int bad = 0;
    @(negedge clk);
    i_cmd_v = 1'b1;
    i_cmd_a = 32'h400;
    i_cmd_n = 32'd16;
    @(negedge clk);
    i_cmd_v = 1'b0;
    k = 0;
    while (beats_tot - bt0 < 6 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk_cnt++;
    if (beats_tot - bt0 != 6)
      $display("FAIL t6_reach got=%0d exp=6",
               beats_tot - bt0);
    else pass_cnt++;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_aw_v, o_w_v, o_w_l, o_b_r, o_busy,
         o_done, o_d_r} !== 7'b0)
      $display("FAIL t6_async got=%b exp=0000000",
               {o_aw_v, o_w_v, o_w_l, o_b_r, o_busy,
                o_done, o_d_r});
    else pass_cnt++;
    btr = beats_tot;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (beats_tot != btr)
      $display("FAIL t6_no_beats got=%0d exp=0",
               beats_tot - btr);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
    aw0 = n_aw;
    s0  = src_idx;
    btr = beats_tot;
    do_cmd(32'h0, 32'd4, 200, ok);
    chk_cnt++;
    if (!ok) $display("FAIL t6_done got=timeout exp=done");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (n_aw - aw0 != 1 || aw_a_log[aw0] !== 32'h0 ||
        aw_l_log[aw0] !== 4'd3 || beats_tot - btr != 4)
      $display("FAIL t6_after got=%0d %0h/%0d %0d exp=1 0/3 4",
               n_aw - aw0, aw_a_log[aw0], aw_l_log[aw0],
               beats_tot - btr);
    else pass_cnt++;
    for (int j = 0; j < 4; j++)
      if (mem[j] !== src_data(s0 + j)) bad++;
    chk_cnt++;
    if (bad != 0)
      $display("FAIL t6_mem got=%0d bad exp=0", bad);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_page_split();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
